// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   state_t : FSM state encoding (IDLE/RUN/DONE)
//   cnt_w() : bit-counter width for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit so the counter can hold WIDTH itself without wrapping.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_sub_half_sub.sv
// half_sub: combinational half subtractor.
//   input_a : minuend bit
//   input_b : subtrahend bit
//   answer  : difference bit (a ^ b)
//   borrow  : borrow out (~a & b)
module half_sub (
    input  logic input_a,
    input  logic input_b,
    output logic answer,
    output logic borrow
);

    always_comb begin
        answer = input_a ^ input_b;
        borrow = ~input_a & input_b;
    end

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = a - b mod 2^WIDTH, LSB first,
// one bit per clock, with a start/busy/done handshake.
//   iclk     : clock, rising edge
//   irst     : synchronous active-high reset
//   start    : request, sampled only in IDLE
//   input_a  : minuend, captured on the accepted start
//   input_b  : subtrahend, captured on the accepted start
//   answer   : difference, valid from the done cycle until the next start
//   borrow   : final borrow (1 iff a < b unsigned)
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when answer/borrow become valid
//   overflow : signed overflow, only when SERIAL_SUB_SIGNED_EN is defined
// Optional feature macro: SERIAL_SUB_SIGNED_EN (adds overflow port and the
// operand MSB capture it needs).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic [WIDTH-1:0] answer,
    output logic             borrow,
    output logic             busy,
`ifdef SERIAL_SUB_SIGNED_EN
    output logic             overflow,
`endif
    output logic             done
);

    localparam int unsigned    CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic            bin;

    logic            load, shift, last;
    logic            x1, br1, d, br2, bo;

`ifdef SERIAL_SUB_SIGNED_EN
    logic            a_msb, b_msb;
`endif

    // Full-subtract bit cell from two half subtractors plus an OR.
    half_sub u_hs_lo (
        .input_a (a_sr[0]),
        .input_b (b_sr[0]),
        .answer  (x1),
        .borrow  (br1)
    );

    half_sub u_hs_hi (
        .input_a (x1),
        .input_b (bin),
        .answer  (d),
        .borrow  (br2)
    );

    always_comb begin
        bo = br1 | br2;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            answer <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            if (load) begin
                a_sr <= input_a;
                b_sr <= input_b;
                bin  <= 1'b0;
                cnt  <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
                a_msb <= input_a[WIDTH-1];
                b_msb <= input_b[WIDTH-1];
`endif
            end
            if (shift) begin
                answer <= {d, answer[WIDTH-1:1]};
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                bin    <= bo;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    borrow <= bo;
`ifdef SERIAL_SUB_SIGNED_EN
                    // d is the result MSB being shifted in on this edge.
                    overflow <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    localparam int unsigned WIDTH = 8;

    logic             iclk = 1'b0;
    logic             irst;
    logic             start;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [WIDTH-1:0] answer;
    logic             borrow;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             overflow;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 iclk = ~iclk;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .iclk    (iclk),
        .irst    (irst),
        .start   (start),
        .input_a (input_a),
        .input_b (input_b),
        .answer  (answer),
        .borrow  (borrow),
        .busy    (busy),
`ifdef SERIAL_SUB_SIGNED_EN
        .overflow(overflow),
`endif
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic.
    function automatic int ref_diff(input int a, input int b);
        return ((a - b) + 256) % 256;
    endfunction

    function automatic int ref_borrow(input int a, input int b);
        return (a < b) ? 1 : 0;
    endfunction

    function automatic int ref_ovf(input int a, input int b);
        int sa, sb, sd;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sd = sa - sb;
        return (sd > 127 || sd < -128) ? 1 : 0;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit noisy_start);
        int lat;
        int busy_cyc;
        int ea;
        int eb;
        ea = int'(a);
        eb = int'(b);
        @(negedge iclk);
        input_a = a;
        input_b = b;
        start   = 1'b1;
        @(posedge iclk);
        #1;
        start   = 1'b0;
        input_a = WIDTH'($urandom);
        input_b = WIDTH'($urandom);
        lat      = 0;
        busy_cyc = 0;
        do begin
            @(negedge iclk);
            lat++;
            if (busy) busy_cyc++;
            if (noisy_start && !done) start = 1'($urandom_range(0, 1));
        end while (!done && lat < 30);
        start = 1'b0;
        check("latency", lat, WIDTH + 1);
        check("busy_cycles", busy_cyc, WIDTH);
        check("busy_at_done", busy, 0);
        check("answer", answer, ref_diff(ea, eb));
        check("borrow", borrow, ref_borrow(ea, eb));
`ifdef SERIAL_SUB_SIGNED_EN
        check("overflow", overflow, ref_ovf(ea, eb));
`endif
        @(negedge iclk);
        check("done_one_cycle", done, 0);
        check("answer_held", answer, ref_diff(ea, eb));
    endtask

    initial begin
        int done_seen;
        int pulses;
        int last_t;
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tb;
        logic [WIDTH-1:0] dir_a [8];
        logic [WIDTH-1:0] dir_b [8];

        dir_a = '{8'h5A, 8'h10, 8'h00, 8'hC3, 8'h00, 8'hFF, 8'h80, 8'h05};
        dir_b = '{8'h23, 8'h20, 8'h01, 8'hC3, 8'hFF, 8'h00, 8'h01, 8'h03};

        irst    = 1'b1;
        start   = 1'b0;
        input_a = '0;
        input_b = '0;
        repeat (3) @(posedge iclk);
        #1;
        irst = 1'b0;
        check("rst_answer", answer, 0);
        check("rst_borrow", borrow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef SERIAL_SUB_SIGNED_EN
        check("rst_overflow", overflow, 0);
`endif

        for (int i = 0; i < 8; i++) run_op(dir_a[i], dir_b[i], 1'b0);

        // Reset in the middle of a RUN: partial result discarded, no done.
        @(negedge iclk);
        input_a = 8'h5A;
        input_b = 8'h23;
        start   = 1'b1;
        @(posedge iclk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge iclk);
        @(negedge iclk);
        irst = 1'b1;
        @(posedge iclk);
        #1;
        irst = 1'b0;
        check("midrst_answer", answer, 0);
        check("midrst_borrow", borrow, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
`ifdef SERIAL_SUB_SIGNED_EN
        check("midrst_overflow", overflow, 0);
`endif
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge iclk);
            if (done || busy) done_seen++;
        end
        check("midrst_no_activity", done_seen, 0);
        run_op(8'h5A, 8'h23, 1'b0);

        // Start held high: one result every WIDTH+2 cycles.
        @(negedge iclk);
        input_a = 8'h05;
        input_b = 8'h03;
        start   = 1'b1;
        pulses  = 0;
        last_t  = -1;
        for (int t = 1; t <= 45; t++) begin
            @(negedge iclk);
            if (done) begin
                pulses++;
                check("b2b_answer", answer, 2);
                if (last_t >= 0) check("b2b_period", t - last_t, WIDTH + 2);
                else check("b2b_first", t, WIDTH + 1);
                last_t = t;
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 4);
        repeat (12) @(negedge iclk);

        // Random operands with start toggled during RUN.
        for (int i = 0; i < 40; i++) begin
            ta = WIDTH'($urandom);
            tb = WIDTH'($urandom);
            if (i % 8 == 0) tb = ta;
            run_op(ta, tb, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
